// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes the PLL lock flag and holds downstream logic in
// reset until lock has been stable for SETTLE_CYCLES; forces a HOLD period on lock loss.
module pll_lock_supervisor #(
    parameter int SETTLE_CYCLES = 4000,
    parameter int HOLD_CYCLES   = 64,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    output logic       sys_reset,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] loss_count
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        SETTLE    = 2'b01,
        RUN       = 2'b10,
        HOLD      = 2'b11
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             loss_q, loss_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            loss_q      <= '0;
            sys_reset_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    // The counter restarts from zero on every state entry, so each timed state
    // measures its own full duration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    loss_d  = sat_inc8(loss_q);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so nothing reaches
    // sys_reset combinationally from locked.
    always_comb begin
        sys_reset_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
    end

    assign sys_reset  = sys_reset_q;
    assign ready      = ready_q;
    assign state      = state_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a cycle-level reference model queues the
// expected outputs for every clock edge and a monitor compares them against the DUT.
module tb_pll_lock_supervisor;

    localparam int SETTLE = 8;
    localparam int HOLD   = 4;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic       sys_reset;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;

    typedef struct {
        logic [1:0] st;
        logic       sr;
        logic       rd;
        logic [7:0] lc;
    } exp_t;

    exp_t sbq[$];

    // Reference model: phase follows the spec encoding, timing kept as cycles remaining.
    int m_phase = 0;
    int m_left  = 0;
    int m_loss  = 0;
    bit hist[$];

    pll_lock_supervisor #(
        .SETTLE_CYCLES(SETTLE),
        .HOLD_CYCLES  (HOLD),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .locked    (locked),
        .sys_reset (sys_reset),
        .ready     (ready),
        .state     (state),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_no, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic lk_v);
        bit   ls;
        exp_t e;
        if (!rst_v) begin
            m_phase = 0;
            m_left  = 0;
            m_loss  = 0;
            hist.delete();
        end else begin
            // Lock as seen through the synchronizer: the sample taken SYNC edges ago.
            ls = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
            hist.push_back(lk_v);
            if (hist.size() > 16) void'(hist.pop_front());
            case (m_phase)
                0: if (ls) begin m_phase = 1; m_left = SETTLE; end
                1: begin
                    if (!ls) m_phase = 0;
                    else begin
                        m_left--;
                        if (m_left == 0) m_phase = 2;
                    end
                end
                2: if (!ls) begin
                    m_phase = 3;
                    m_left  = HOLD;
                    if (m_loss < 255) m_loss++;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            endcase
        end
        e.st = m_phase[1:0];
        e.sr = (m_phase == 2);
        e.rd = (m_phase == 2);
        e.lc = m_loss[7:0];
        sbq.push_back(e);
    endtask

    // Drive inputs away from the active edge, then record the expectation for the edge.
    task automatic cyc(input logic rst_v, input logic lk_v);
        @(negedge clk);
        reset  = rst_v;
        locked = lk_v;
        @(posedge clk);
        edge_no++;
        model_edge(rst_v, lk_v);
    endtask

    task automatic cycn(input logic rst_v, input logic lk_v, input int n);
        for (int i = 0; i < n; i++) cyc(rst_v, lk_v);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_state", int'(state), int'(e.st));
            chk("sb_sys_reset", int'(sys_reset), int'(e.sr));
            chk("sb_ready", int'(ready), int'(e.rd));
            chk("sb_loss_count", int'(loss_count), int'(e.lc));
        end
    end

    initial begin
        reset  = 1'b1;
        locked = 1'b0;
        #1 reset = 1'b0;

        // Power-on reset with the PLL unlocked.
        cycn(1'b0, 1'b0, 3);
        cycn(1'b1, 1'b0, 3);

        // Lock appears, then glitches away mid-settle, then returns for a full settle.
        cycn(1'b1, 1'b1, 8);
        cycn(1'b1, 1'b0, 3);
        cycn(1'b1, 1'b1, 14);

        // Lock loss from RUN with immediate relock.
        cyc(1'b1, 1'b0);
        cycn(1'b1, 1'b1, 20);

        // Repeated loss/relock until the loss counter saturates.
        for (int i = 0; i < 299; i++) begin
            cyc(1'b1, 1'b0);
            cycn(1'b1, 1'b1, 20);
        end
        #2;
        chk("sat_loss_count", int'(loss_count), 255);
        chk("run_before_async", int'(sys_reset), 1);

        // Asynchronous reset asserted between clock edges while in RUN.
        #1 reset = 1'b0;
        #1;
        chk("async_sys_reset", int'(sys_reset), 0);
        chk("async_ready", int'(ready), 0);
        chk("async_state", int'(state), 0);
        chk("async_loss_count", int'(loss_count), 0);
        cycn(1'b0, 1'b1, 2);

        // Random lock waveform with occasional reset pulses.
        for (int s = 0; s < 60; s++) begin
            int len;
            logic lk;
            len = $urandom_range(1, 24);
            lk  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) cycn(1'b0, lk, $urandom_range(1, 3));
            cycn(1'b1, lk, len);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer end of the PLL's lock indication; runs in the PLL output clock domain (40 MHz global clock).
- Synchronizes the asynchronous PLL lock flag and holds downstream logic (quadrature blocks etc.) in reset until lock is stable for a programmable settle time.
- Re-asserts the downstream reset for a minimum hold period on any lock loss, and counts lock-loss events.

Parameters:
- SETTLE_CYCLES, 4000, consecutive synchronized-lock cycles required before release (100 us at 40 MHz); must be >= 1.
- HOLD_CYCLES, 64, minimum cycles sys_reset stays asserted after a lock loss; must be >= 1.
- SYNC_STAGES, 2, flip-flop stages in the lock synchronizer; must be >= 2.

Ports:
- clk  input  1  PLL global clock output; all logic on rising edge.
- reset  input  1  asynchronous, active-low master reset (board/power-on).
- locked  input  1  PLL lock flag, asynchronous to clk; may glitch.
- sys_reset  output  1  active-low reset to downstream logic; asserts asynchronously with reset, deasserts only synchronously.
- ready  output  1  high exactly when state is RUN.
- state  output  2  00 WAIT_LOCK, 01 SETTLE, 10 RUN, 11 HOLD.
- loss_count  output  8  number of RUN->HOLD transitions, saturating at 255.

Behaviour:
- Reset low (async): synchronizer flops 0, state WAIT_LOCK, counter 0, sys_reset 0, ready 0, loss_count 0. Reset low mid-operation aborts any state immediately with these values.
- locked_s = last synchronizer stage. locked held high from before edge k gives locked_s = 1 after edge k+SYNC_STAGES-1.
- Single counter cnt, wide enough for max(SETTLE_CYCLES, HOLD_CYCLES)-1; cleared on every state entry.
- WAIT_LOCK: sys_reset 0. On an edge with locked_s=1, go to SETTLE.
- SETTLE: sys_reset 0.
  - On an edge with locked_s=0, go to WAIT_LOCK. Glitch: no loss_count change.
  - Else if cnt==SETTLE_CYCLES-1, go to RUN and set sys_reset to 1 on the same edge.
  - Else cnt++.
  - SETTLE therefore lasts exactly SETTLE_CYCLES edges.
- Release latency: sys_reset rises after edge k+SYNC_STAGES+SETTLE_CYCLES.
- RUN: sys_reset 1, ready 1. On an edge with locked_s=0: go to HOLD, sys_reset 0, loss_count++ (saturating; stays 255 at 255).
- Loss latency: locked falling before edge m gives sys_reset low after edge m+SYNC_STAGES.
- HOLD: sys_reset 0; locked_s is ignored. At cnt==HOLD_CYCLES-1 go to WAIT_LOCK, else cnt++. HOLD lasts exactly HOLD_CYCLES edges.
- From WAIT_LOCK with lock already stable, SETTLE starts on the next edge. The full SETTLE period always precedes re-release.
- All outputs are registered; no combinational path from locked or state to sys_reset.
- reset deassertion: the first possible state change is on the first edge after release.

Test Plan:
- SETTLE_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2; reset low 3 cycles, locked=0 -> sys_reset=0, ready=0, state=00, loss_count=0 throughout.
- Release reset, raise locked before edge k -> state=01 after edge k+2; sys_reset=1, ready=1, state=10 after edge k+10, not earlier.
- In SETTLE, drop locked for 3 cycles at cnt=5 -> state returns to 00, loss_count stays 0. On lock return, full 8-cycle settle is repeated before sys_reset=1.
- In RUN, drop locked before edge m -> sys_reset=0, state=11 after edge m+2, loss_count=1. With locked restored immediately: state=00 after edge m+6, state=01 after edge m+7, sys_reset=1 after edge m+15.
- 300 RUN loss/relock cycles -> loss_count saturates at 255, never wraps.
- Assert reset while in RUN mid-cycle -> sys_reset drops before the next clk edge; all outputs return to reset values.
